// File: rtl/pipe_control_path.sv
// Pipelined RV32I control path: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// and EX-stage branch/jump resolution from ALU flags.
module pipe_control_path #(
    parameter int unsigned ALUCTL_W    = 3,
    parameter bit          FULL_BRANCH = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          op_d,
    input  logic [2:0]          funct3_d,
    input  logic                funct7b5_d,
    input  logic                valid_d,
    input  logic                flush_e,
    input  logic                zero_e,
    input  logic                lt_e,
    input  logic                ltu_e,
    output logic [2:0]          imm_src_d,
    output logic                illegal_d,
    output logic                alu_src_e,
    output logic                alu_srca_e,
    output logic [ALUCTL_W-1:0] alu_control_e,
    output logic [1:0]          pcsrc_e,
    output logic                redirect_e,
    output logic                resultsrc_e0,
    output logic                regwrite_m,
    output logic                memwrite_m,
    output logic                regwrite_w,
    output logic [1:0]          resultsrc_w
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Highest ALU code reachable with a 3-bit control (slt)
    localparam logic [3:0] ALU_MAX_NARROW = 4'd5;

    typedef struct packed {
        logic                regwrite;
        logic [1:0]          resultsrc;
        logic                memwrite;
        logic                jump;
        logic                jalr;
        logic                branch;
        logic                alu_src;
        logic                alu_srca;
        logic [ALUCTL_W-1:0] alu_control;
        logic [2:0]          funct3;
    } idex_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
    } exmem_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
    } memwb_t;

    idex_t  dec_d;
    idex_t  ex_q;
    exmem_t mem_q;
    memwb_t wb_q;
    logic   bad_d;
    logic   taken_e;
    logic   cond_e;

    // ALU code for R-type / I-type arithmetic; sub only exists in R-type
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic f7b5,
                                          input logic is_r);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (is_r && f7b5) ? 4'd1 : 4'd0;
            3'b001:  code = 4'd7;
            3'b010:  code = 4'd5;
            3'b011:  code = 4'd6;
            3'b100:  code = 4'd4;
            3'b101:  code = f7b5 ? 4'd9 : 4'd8;
            3'b110:  code = 4'd3;
            default: code = 4'd2;
        endcase
        return code;
    endfunction

    // ID decode: control bundle, immediate format and legality
    always_comb begin
        logic [3:0] alu_op;
        dec_d     = '0;
        alu_op    = 4'd0;
        imm_src_d = 3'b000;
        bad_d     = 1'b0;
        case (op_d)
            OP_LW: begin
                dec_d.regwrite  = 1'b1;
                dec_d.resultsrc = 2'b01;
                dec_d.alu_src   = 1'b1;
            end
            OP_SW: begin
                dec_d.memwrite = 1'b1;
                dec_d.alu_src  = 1'b1;
                imm_src_d      = 3'b001;
            end
            OP_R: begin
                dec_d.regwrite = 1'b1;
                alu_op         = alu_fn(funct3_d, funct7b5_d, 1'b1);
            end
            OP_I: begin
                dec_d.regwrite = 1'b1;
                dec_d.alu_src  = 1'b1;
                alu_op         = alu_fn(funct3_d, funct7b5_d, 1'b0);
            end
            OP_BR: begin
                dec_d.branch = 1'b1;
                alu_op       = 4'd1;
                imm_src_d    = 3'b010;
                if (funct3_d[2:1] == 2'b01)
                    bad_d = 1'b1;
                if (!FULL_BRANCH && funct3_d[2])
                    bad_d = 1'b1;
            end
            OP_JAL: begin
                dec_d.regwrite  = 1'b1;
                dec_d.resultsrc = 2'b10;
                dec_d.jump      = 1'b1;
                imm_src_d       = 3'b011;
            end
            OP_JALR: begin
                dec_d.regwrite  = 1'b1;
                dec_d.resultsrc = 2'b10;
                dec_d.jump      = 1'b1;
                dec_d.jalr      = 1'b1;
                dec_d.alu_src   = 1'b1;
            end
            OP_LUI: begin
                dec_d.regwrite  = 1'b1;
                dec_d.resultsrc = 2'b11;
                imm_src_d       = 3'b100;
            end
            OP_AUIPC: begin
                dec_d.regwrite = 1'b1;
                dec_d.alu_src  = 1'b1;
                dec_d.alu_srca = 1'b1;
                imm_src_d      = 3'b100;
            end
            default: bad_d = 1'b1;
        endcase
        if (ALUCTL_W < 4 && alu_op > ALU_MAX_NARROW)
            bad_d = 1'b1;
        dec_d.alu_control = ALUCTL_W'(alu_op);
        dec_d.funct3      = funct3_d;
    end

    assign illegal_d = bad_d;

    // ID/EX register: reset, then flush, then bubble for invalid/illegal, else decode
    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= '0;
        else if (flush_e || !valid_d || bad_d)
            ex_q <= '0;
        else
            ex_q <= dec_d;
    end

    // EX branch condition select and PC source
    always_comb begin
        cond_e = 1'b0;
        case (ex_q.funct3)
            3'b000:  cond_e = zero_e;
            3'b001:  cond_e = !zero_e;
            3'b100:  cond_e = lt_e;
            3'b101:  cond_e = !lt_e;
            3'b110:  cond_e = ltu_e;
            3'b111:  cond_e = !ltu_e;
            default: cond_e = 1'b0;
        endcase
        taken_e = (ex_q.branch & cond_e) | ex_q.jump;
    end

    assign pcsrc_e    = {ex_q.jalr, taken_e};
    assign redirect_e = taken_e;

    // EX/MEM and MEM/WB registers always advance
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= '{regwrite: ex_q.regwrite, resultsrc: ex_q.resultsrc,
                       memwrite: ex_q.memwrite};
            wb_q  <= '{regwrite: mem_q.regwrite, resultsrc: mem_q.resultsrc};
        end
    end

    assign alu_src_e     = ex_q.alu_src;
    assign alu_srca_e    = ex_q.alu_srca;
    assign alu_control_e = ex_q.alu_control;
    assign resultsrc_e0  = ex_q.resultsrc[0];
    assign regwrite_m    = mem_q.regwrite;
    assign memwrite_m    = mem_q.memwrite;
    assign regwrite_w    = wb_q.regwrite;
    assign resultsrc_w   = wb_q.resultsrc;

endmodule

// File: tb/tb_pipe_control_path.sv
// Table-driven bench for pipe_control_path: default build plus a 4-bit ALU,
// BEQ/BNE-only build sharing the same stimulus.
module tb_pipe_control_path;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic       funct7b5_d, valid_d, flush_e, zero_e, lt_e, ltu_e;

    logic [2:0] imm_src_d;
    logic       illegal_d, alu_src_e, alu_srca_e, redirect_e, resultsrc_e0;
    logic [2:0] alu_control_e;
    logic [1:0] pcsrc_e, resultsrc_w;
    logic       regwrite_m, memwrite_m, regwrite_w;

    logic [2:0] a_imm_src_d;
    logic       a_illegal_d, a_alu_src_e, a_alu_srca_e, a_redirect_e, a_resultsrc_e0;
    logic [3:0] a_alu_control_e;
    logic [1:0] a_pcsrc_e, a_resultsrc_w;
    logic       a_regwrite_m, a_memwrite_m, a_regwrite_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_control_path u_dut (
        .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
        .valid_d(valid_d), .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d), .alu_src_e(alu_src_e),
        .alu_srca_e(alu_srca_e), .alu_control_e(alu_control_e), .pcsrc_e(pcsrc_e),
        .redirect_e(redirect_e), .resultsrc_e0(resultsrc_e0), .regwrite_m(regwrite_m),
        .memwrite_m(memwrite_m), .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w)
    );

    pipe_control_path #(.ALUCTL_W(4), .FULL_BRANCH(1'b0)) u_alt (
        .clk(clk), .rst(rst), .op_d(op_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
        .valid_d(valid_d), .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(a_imm_src_d), .illegal_d(a_illegal_d), .alu_src_e(a_alu_src_e),
        .alu_srca_e(a_alu_srca_e), .alu_control_e(a_alu_control_e), .pcsrc_e(a_pcsrc_e),
        .redirect_e(a_redirect_e), .resultsrc_e0(a_resultsrc_e0), .regwrite_m(a_regwrite_m),
        .memwrite_m(a_memwrite_m), .regwrite_w(a_regwrite_w), .resultsrc_w(a_resultsrc_w)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, v, fl, z, lt, ltu;
        logic       ill;
        logic [2:0] imm;
        logic       asrc, asrca;
        logic [3:0] actl;
        logic [1:0] pc;
        logic       e0, rw, mw;
        logic [1:0] rs;
    } vec_t;

    vec_t tbl[$];
    vec_t t, p1, p2;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // op f3 f7 v fl z lt ltu | ill imm asrc asrca actl pc e0 rw mw rs
    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic v, input logic fl, input logic z, input logic lt,
                           input logic ltu, input logic ill, input logic [2:0] imm,
                           input logic asrc, input logic asrca, input logic [3:0] actl,
                           input logic [1:0] pc, input logic e0, input logic rw,
                           input logic mw, input logic [1:0] rs);
        vec_t r;
        r.op = op; r.f3 = f3; r.f7 = f7; r.v = v; r.fl = fl;
        r.z = z; r.lt = lt; r.ltu = ltu; r.ill = ill; r.imm = imm;
        r.asrc = asrc; r.asrca = asrca; r.actl = actl; r.pc = pc;
        r.e0 = e0; r.rw = rw; r.mw = mw; r.rs = rs;
        tbl.push_back(r);
    endtask

    task automatic drive_id(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic v, input logic fl);
        op_d = op; funct3_d = f3; funct7b5_d = f7; valid_d = v; flush_e = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".alu_src_e"},     int'(alu_src_e), 0);
        chk({name, ".alu_control_e"}, int'(alu_control_e), 0);
        chk({name, ".pcsrc_e"},       int'(pcsrc_e), 0);
        chk({name, ".resultsrc_e0"},  int'(resultsrc_e0), 0);
        chk({name, ".regwrite_m"},    int'(regwrite_m), 0);
        chk({name, ".memwrite_m"},    int'(memwrite_m), 0);
        chk({name, ".regwrite_w"},    int'(regwrite_w), 0);
        chk({name, ".resultsrc_w"},   int'(resultsrc_w), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // R / I arithmetic
        add_vec(7'b0110011, 3'b000, 0, 1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 4'd0, 2'b00, 0, 1, 0, 2'b00);
        add_vec(7'b0110011, 3'b000, 1, 1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 4'd1, 2'b00, 0, 1, 0, 2'b00);
        add_vec(7'b0110011, 3'b111, 0, 1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 4'd2, 2'b00, 0, 1, 0, 2'b00);
        add_vec(7'b0110011, 3'b110, 0, 1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 4'd3, 2'b00, 0, 1, 0, 2'b00);
        add_vec(7'b0110011, 3'b100, 0, 1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 4'd4, 2'b00, 0, 1, 0, 2'b00);
        add_vec(7'b0110011, 3'b010, 0, 1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 4'd5, 2'b00, 0, 1, 0, 2'b00);
        add_vec(7'b0010011, 3'b000, 1, 1, 0, 0, 0, 0,  0, 3'b000, 1, 0, 4'd0, 2'b00, 0, 1, 0, 2'b00);
        add_vec(7'b0010011, 3'b010, 0, 1, 0, 0, 0, 0,  0, 3'b000, 1, 0, 4'd5, 2'b00, 0, 1, 0, 2'b00);
        // loads and stores; lw flushed behind sw
        add_vec(7'b0000011, 3'b010, 0, 1, 0, 0, 0, 0,  0, 3'b000, 1, 0, 4'd0, 2'b00, 1, 1, 0, 2'b01);
        add_vec(7'b0100011, 3'b010, 0, 1, 0, 0, 0, 0,  0, 3'b001, 1, 0, 4'd0, 2'b00, 0, 0, 1, 2'b00);
        add_vec(7'b0000011, 3'b010, 0, 1, 1, 0, 0, 0,  0, 3'b000, 0, 0, 4'd0, 2'b00, 0, 0, 0, 2'b00);
        // branches
        add_vec(7'b1100011, 3'b000, 0, 1, 0, 1, 0, 0,  0, 3'b010, 0, 0, 4'd1, 2'b01, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b000, 0, 1, 0, 0, 0, 0,  0, 3'b010, 0, 0, 4'd1, 2'b00, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b001, 0, 1, 0, 0, 0, 0,  0, 3'b010, 0, 0, 4'd1, 2'b01, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b100, 0, 1, 0, 0, 1, 0,  0, 3'b010, 0, 0, 4'd1, 2'b01, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b100, 0, 1, 0, 0, 0, 0,  0, 3'b010, 0, 0, 4'd1, 2'b00, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b101, 0, 1, 0, 0, 0, 1,  0, 3'b010, 0, 0, 4'd1, 2'b01, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b110, 0, 1, 0, 0, 0, 1,  0, 3'b010, 0, 0, 4'd1, 2'b01, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b111, 0, 1, 0, 0, 0, 1,  0, 3'b010, 0, 0, 4'd1, 2'b00, 0, 0, 0, 2'b00);
        // jumps and upper immediates
        add_vec(7'b1101111, 3'b000, 0, 1, 0, 0, 0, 0,  0, 3'b011, 0, 0, 4'd0, 2'b01, 0, 1, 0, 2'b10);
        add_vec(7'b1100111, 3'b000, 0, 1, 0, 0, 0, 0,  0, 3'b000, 1, 0, 4'd0, 2'b11, 0, 1, 0, 2'b10);
        add_vec(7'b0110111, 3'b000, 0, 1, 0, 0, 0, 0,  0, 3'b100, 0, 0, 4'd0, 2'b00, 1, 1, 0, 2'b11);
        add_vec(7'b0010111, 3'b000, 0, 1, 0, 0, 0, 0,  0, 3'b100, 1, 1, 4'd0, 2'b00, 0, 1, 0, 2'b00);
        // illegal encodings and invalid slot become bubbles
        add_vec(7'b0010011, 3'b101, 1, 1, 0, 0, 0, 0,  1, 3'b000, 0, 0, 4'd0, 2'b00, 0, 0, 0, 2'b00);
        add_vec(7'b0110011, 3'b001, 0, 1, 0, 0, 0, 0,  1, 3'b000, 0, 0, 4'd0, 2'b00, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b010, 0, 1, 0, 1, 1, 1,  1, 3'b010, 0, 0, 4'd0, 2'b00, 0, 0, 0, 2'b00);
        add_vec(7'b1111111, 3'b000, 0, 1, 0, 0, 0, 0,  1, 3'b000, 0, 0, 4'd0, 2'b00, 0, 0, 0, 2'b00);
        add_vec(7'b1100011, 3'b000, 0, 0, 0, 1, 0, 0,  0, 3'b010, 0, 0, 4'd0, 2'b00, 0, 0, 0, 2'b00);
        add_vec(7'b0110011, 3'b000, 0, 1, 0, 0, 0, 0,  0, 3'b000, 0, 0, 4'd0, 2'b00, 0, 1, 0, 2'b00);

        // initial reset
        rst = 1'b1;
        drive_id(7'b0, 3'b0, 1'b0, 1'b0, 1'b0);
        zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        p1 = '{default: '0};
        p2 = '{default: '0};

        // vector table: ID checks before the edge, EX/MEM/WB after it
        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            drive_id(t.op, t.f3, t.f7, t.v, t.fl);
            #1;
            chk($sformatf("v%0d.illegal_d", i), int'(illegal_d), int'(t.ill));
            chk($sformatf("v%0d.imm_src_d", i), int'(imm_src_d), int'(t.imm));
            @(posedge clk);
            zero_e = t.z; lt_e = t.lt; ltu_e = t.ltu;
            #1;
            chk($sformatf("v%0d.alu_src_e", i),     int'(alu_src_e), int'(t.asrc));
            chk($sformatf("v%0d.alu_srca_e", i),    int'(alu_srca_e), int'(t.asrca));
            chk($sformatf("v%0d.alu_control_e", i), int'(alu_control_e), int'(t.actl));
            chk($sformatf("v%0d.pcsrc_e", i),       int'(pcsrc_e), int'(t.pc));
            chk($sformatf("v%0d.redirect_e", i),    int'(redirect_e), int'(t.pc[0]));
            chk($sformatf("v%0d.resultsrc_e0", i),  int'(resultsrc_e0), int'(t.e0));
            chk($sformatf("v%0d.regwrite_m", i),    int'(regwrite_m), int'(p1.rw));
            chk($sformatf("v%0d.memwrite_m", i),    int'(memwrite_m), int'(p1.mw));
            chk($sformatf("v%0d.regwrite_w", i),    int'(regwrite_w), int'(p2.rw));
            chk($sformatf("v%0d.resultsrc_w", i),   int'(resultsrc_w), int'(p2.rs));
            p2 = p1;
            p1 = t;
        end

        // flush alongside a redirect: jal resolves, the instruction behind it is dropped
        zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
        drive_id(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        drive_id(7'b0110011, 3'b000, 1'b0, 1'b1, 1'b1);
        #1;
        chk("flushred.redirect_e", int'(redirect_e), 1);
        chk("flushred.pcsrc_e", int'(pcsrc_e), 1);
        tick();
        drive_id(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("flushred.bubble_pcsrc", int'(pcsrc_e), 0);
        chk("flushred.jal_regwrite_m", int'(regwrite_m), 1);
        tick();
        chk("flushred.bubble_regwrite_m", int'(regwrite_m), 0);
        chk("flushred.jal_regwrite_w", int'(regwrite_w), 1);
        chk("flushred.jal_resultsrc_w", int'(resultsrc_w), 2);
        tick();
        chk("flushred.bubble_regwrite_w", int'(regwrite_w), 0);

        // reset held two cycles with lw in EX and jal in ID discards everything
        drive_id(7'b0000011, 3'b010, 1'b0, 1'b1, 1'b0);
        tick();
        chk("midrst.lw_in_ex", int'(resultsrc_e0), 1);
        drive_id(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_zero("midrst1");
        tick();
        chk_zero("midrst2");
        rst = 1'b0;
        drive_id(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_zero($sformatf("postrst%0d", k));
        end

        // 4-bit ALU, BEQ/BNE-only build
        drive_id(7'b0010011, 3'b101, 1'b1, 1'b1, 1'b0);
        #1;
        chk("alt.srai_illegal", int'(a_illegal_d), 0);
        chk("dut.srai_illegal", int'(illegal_d), 1);
        tick();
        chk("alt.srai_alu_control", int'(a_alu_control_e), 9);
        chk("alt.srai_alu_src", int'(a_alu_src_e), 1);
        chk("dut.srai_bubble", int'(alu_src_e), 0);
        drive_id(7'b0110011, 3'b011, 1'b0, 1'b1, 1'b0);
        tick();
        chk("alt.sltu_alu_control", int'(a_alu_control_e), 6);
        chk("alt.sltu_alu_src", int'(a_alu_src_e), 0);
        drive_id(7'b0110011, 3'b101, 1'b0, 1'b1, 1'b0);
        tick();
        chk("alt.srl_alu_control", int'(a_alu_control_e), 8);
        drive_id(7'b1100011, 3'b100, 1'b0, 1'b1, 1'b0);
        lt_e = 1'b1;
        #1;
        chk("alt.blt_illegal", int'(a_illegal_d), 1);
        chk("dut.blt_illegal", int'(illegal_d), 0);
        tick();
        chk("alt.blt_pcsrc", int'(a_pcsrc_e), 0);
        chk("dut.blt_pcsrc", int'(pcsrc_e), 1);
        drive_id(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0);
        zero_e = 1'b0;
        tick();
        chk("alt.bne_pcsrc", int'(a_pcsrc_e), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
